// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
//   state_t : control FSM state encoding
//   steps() : number of clock steps needed to process a WIDTH-bit operand DIGIT bits at a time
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned steps(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry adder slice.
//   a, b   : DIGIT-bit operand slices
//   cin    : carry in
//   sum_c  : DIGIT-bit sum
//   cout_c : carry out of the slice MSB
module addsub_digit #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum_c,
    output logic             cout_c
);

    logic [DIGIT:0] c;

    // Explicit ripple chain, one full adder per bit.
    always_comb begin
        c      = '0;
        sum_c  = '0;
        c[0]   = cin;
        for (int i = 0; i < int'(DIGIT); i++) begin
            sum_c[i] = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout_c = c[DIGIT];
    end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor with valid/ready on both sides.
// Processes DIGIT bits per clock; a result appears WIDTH/DIGIT clocks after accept.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake (a, b, sub sampled on accept)
//   out_valid/out_ready  : result handshake
//   result               : a+b or a-b mod 2^WIDTH
//   carry_out, borrow    : carry out of MSB; unsigned a<b in subtract mode
//   overflow             : signed overflow
//   negative, zero       : result MSB; result == 0
module addsub_serial import addsub_pkg::*; #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             borrow,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);

    localparam int unsigned STEPS = steps(WIDTH, DIGIT);
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    // Reject illegal parameterisations at elaboration.
    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_err
        $error("addsub_serial: WIDTH must be >= 2 and divisible by DIGIT");
    end

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             sub_q;
    logic             a_msb;
    logic             b_msb;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] sum_c;
    logic             cout_c;
    logic [WIDTH-1:0] res_nxt_c;
    logic             accept_c;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a      (a_sh[DIGIT-1:0]),
        .b      (b_sh[DIGIT-1:0]),
        .cin    (carry),
        .sum_c  (sum_c),
        .cout_c (cout_c)
    );

    // New sum digit enters the result register from the MSB side.
    assign res_nxt_c = (result >> DIGIT) | (WIDTH'(sum_c) << (WIDTH - DIGIT));
    assign accept_c  = (state == IDLE) && in_valid;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)      state_nxt = RUN;
            RUN:     if (cnt == LAST)   state_nxt = DONE;
            DONE:    if (out_ready)     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Handshake outputs, operand shifters, result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            carry     <= 1'b0;
            sub_q     <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            if (accept_c) begin
                // Subtraction is a + ~b + 1: invert b and seed the carry.
                a_sh  <= a;
                b_sh  <= b ^ {WIDTH{sub}};
                carry <= sub;
                sub_q <= sub;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1] ^ sub;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> DIGIT;
                b_sh   <= b_sh >> DIGIT;
                carry  <= cout_c;
                result <= res_nxt_c;
                cnt    <= cnt + CW'(1);
                if (cnt == LAST) begin
                    carry_out <= cout_c;
                    borrow    <= sub_q & ~cout_c;
                    overflow  <= (a_msb == b_msb) && (res_nxt_c[WIDTH-1] != a_msb);
                    negative  <= res_nxt_c[WIDTH-1];
                    zero      <= (res_nxt_c == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed and model-based bench for addsub_serial (8-bit/1-digit and 16-bit/4-digit instances).
module tb_addsub_serial;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       in_valid8, in_ready8, sub8, out_valid8, out_ready8;
    logic       carry8, borrow8, ovf8, neg8, zero8;
    logic [7:0] a8, b8, res8;

    logic        in_valid16, in_ready16, sub16, out_valid16, out_ready16;
    logic        carry16, borrow16, ovf16, neg16, zero16;
    logic [15:0] a16, b16, res16;

    int checks = 0;
    int errors = 0;

    addsub_serial #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .result(res8), .carry_out(carry8), .borrow(borrow8),
        .overflow(ovf8), .negative(neg8), .zero(zero8)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .result(res16), .carry_out(carry16), .borrow(borrow16),
        .overflow(ovf16), .negative(neg16), .zero(zero16)
    );

    // Drive one 8-bit operation; returns {result,carry,borrow,ovf,neg,zero} and cycles from accept edge.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [12:0] got, output int lat);
        int n = 0;
        out_ready8 = 1'b1;
        while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
        in_valid8 = 1'b1; a8 = a; b8 = b; sub8 = s;
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 100) begin @(negedge clk); lat++; end
        got = {res8, carry8, borrow8, ovf8, neg8, zero8};
        @(negedge clk);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [20:0] got, output int lat);
        int n = 0;
        out_ready16 = 1'b1;
        while (!in_ready16 && n < 50) begin @(negedge clk); n++; end
        in_valid16 = 1'b1; a16 = a; b16 = b; sub16 = s;
        @(negedge clk);
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 100) begin @(negedge clk); lat++; end
        got = {res16, carry16, borrow16, ovf16, neg16, zero16};
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready8, out_valid8, res8, carry8, borrow8, ovf8, neg8, zero8} !== {2'b10, 8'h00, 5'b0}) begin
            errors++;
            $display("FAIL reset8 got ir/ov/res/flags=%b/%b/%h/%b exp 1/0/00/00000",
                     in_ready8, out_valid8, res8, {carry8, borrow8, ovf8, neg8, zero8});
        end
        checks++;
        if ({in_ready16, out_valid16, res16, carry16, borrow16, ovf16, neg16, zero16} !== {2'b10, 16'h0, 5'b0}) begin
            errors++;
            $display("FAIL reset16 got ir/ov/res/flags=%b/%b/%h/%b exp 1/0/0000/00000",
                     in_ready16, out_valid16, res16, {carry16, borrow16, ovf16, neg16, zero16});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Flag vectors: {result, carry, borrow, overflow, negative, zero}.
    task automatic test_vectors8();
        logic [7:0]  va [6] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'hFF, 8'h00};
        logic [7:0]  vb [6] = '{8'h03, 8'h05, 8'h01, 8'h01, 8'h01, 8'h00};
        logic        vs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [12:0] ve [6] = '{{8'h02, 5'b10000}, {8'hFE, 5'b01010}, {8'h7F, 5'b10100},
                                {8'h80, 5'b00110}, {8'h00, 5'b10001}, {8'h00, 5'b10001}};
        logic [12:0] got;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run8(va[i], vb[i], vs[i], got, lat);
            checks++;
            if (got !== ve[i]) begin
                errors++;
                $display("FAIL vec8[%0d] got res/flags=%h/%b exp %h/%b", i, got[12:5], got[4:0], ve[i][12:5], ve[i][4:0]);
            end
            checks++;
            if (lat !== 8) begin
                errors++;
                $display("FAIL lat8[%0d] got %0d exp 8", i, lat);
            end
            checks++;
            if ({in_ready8, out_valid8} !== 2'b10) begin
                errors++;
                $display("FAIL post_hs8[%0d] got ir/ov=%b/%b exp 1/0", i, in_ready8, out_valid8);
            end
        end
    endtask

    task automatic test_hold();
        int n = 0;
        out_ready8 = 1'b0;
        while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
        in_valid8 = 1'b1; a8 = 8'h40; b8 = 8'h30; sub8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 100) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid8, in_ready8, res8, carry8, borrow8, ovf8, neg8, zero8} !== {2'b10, 8'h70, 5'b00000}) begin
                errors++;
                $display("FAIL hold[%0d] got ov/ir/res/flags=%b/%b/%h/%b exp 1/0/70/00000",
                         i, out_valid8, in_ready8, res8, {carry8, borrow8, ovf8, neg8, zero8});
            end
            in_valid8 = ~in_valid8;
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            sub8 = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid8, in_ready8} !== 2'b01) begin
            errors++;
            $display("FAIL hold_release got ov/ir=%b/%b exp 0/1", out_valid8, in_ready8);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid8, in_ready8} !== 2'b01) begin
            errors++;
            $display("FAIL hold_single_hs got ov/ir=%b/%b exp 0/1", out_valid8, in_ready8);
        end
    endtask

    // in_valid held high: result handshakes must be STEPS+2 = 10 cycles apart.
    task automatic test_back_to_back();
        int n = 0;
        out_ready8 = 1'b1;
        in_valid8 = 1'b1; a8 = 8'h01; b8 = 8'h01; sub8 = 1'b0;
        while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (res8 !== 8'h02) begin
            errors++;
            $display("FAIL b2b_res got %h exp 02", res8);
        end
        @(negedge clk);
        n = 1;
        while (!out_valid8 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL b2b_period got %0d exp 10", n);
        end
        in_valid8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [12:0] got;
        int lat;
        int n = 0;
        out_ready8 = 1'b1;
        while (!in_ready8 && n < 50) begin @(negedge clk); n++; end
        in_valid8 = 1'b1; a8 = 8'h55; b8 = 8'h11; sub8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready8, out_valid8, res8, carry8, borrow8, ovf8, neg8, zero8} !== {2'b10, 8'h00, 5'b0}) begin
            errors++;
            $display("FAIL mid_reset got ir/ov/res/flags=%b/%b/%h/%b exp 1/0/00/00000",
                     in_ready8, out_valid8, res8, {carry8, borrow8, ovf8, neg8, zero8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run8(8'h10, 8'h01, 1'b1, got, lat);
        checks++;
        if (got !== {8'h0F, 5'b10000} || lat !== 8) begin
            errors++;
            $display("FAIL after_reset got res/flags/lat=%h/%b/%0d exp 0f/10000/8", got[12:5], got[4:0], lat);
        end
    endtask

    task automatic test_wide();
        logic [20:0] got;
        logic [20:0] exp;
        logic [15:0] ra, rb, r;
        logic        rs, c, ov;
        int lat, sa, sb, t;
        run16(16'h1234, 16'h0235, 1'b1, got, lat);
        checks++;
        if (got !== {16'h0FFF, 5'b10000} || lat !== 4) begin
            errors++;
            $display("FAIL wide_dir got res/flags/lat=%h/%b/%0d exp 0fff/10000/4", got[20:5], got[4:0], lat);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            sa = int'($signed(ra));
            sb = int'($signed(rb));
            t  = rs ? (sa - sb) : (sa + sb);
            r  = 16'(t);
            ov = (t > 32767) || (t < -32768);
            c  = rs ? (ra >= rb) : ((int'(ra) + int'(rb)) > 65535);
            exp = {r, c, rs & ~c, ov, r[15], (r == 16'h0)};
            run16(ra, rb, rs, got, lat);
            checks++;
            if (got !== exp || lat !== 4) begin
                errors++;
                $display("FAIL wide_rand[%0d] a=%h b=%h sub=%b got res/flags/lat=%h/%b/%0d exp %h/%b/4",
                         i, ra, rb, rs, got[20:5], got[4:0], lat, exp[20:5], exp[4:0]);
            end
        end
    endtask

    initial begin
        in_valid8  = 1'b0; a8  = '0; b8  = '0; sub8  = 1'b0; out_ready8  = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; out_ready16 = 1'b0;
        test_reset();
        test_vectors8();
        test_hold();
        test_back_to_back();
        test_reset_mid_run();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
